// File: rtl/irq_host_pkg.sv
// Shared types and constants for the interrupt host agent.
//   host_state_e    : sequencing FSM states
//   PREADY_TIMEOUT  : access cycles with pready low before an access is abandoned
//   TIMEOUT_W       : width of the pready wait counter
//   SERVICE_COUNT_MAX : saturation value of the service counter
package irq_host_pkg;

    typedef enum logic [3:0] {
        IDLE,
        WR_ACC,
        WR_GAP,
        RD_ACC,
        RD_GAP,
        READY,
        SERVICE,
        ACK,
        HOLD
    } host_state_e;

    localparam int unsigned PREADY_TIMEOUT    = 16;
    localparam int unsigned TIMEOUT_W         = $clog2(PREADY_TIMEOUT);
    localparam logic [15:0] SERVICE_COUNT_MAX = 16'hFFFF;

endpackage

// File: rtl/irq_apb_engine.sv
// Single APB access engine: launches one read or write, holds the bus stable
// until pready or until the wait budget expires, then releases the bus.
// Ports:
//   pclk, preset                 : clock, synchronous active-high reset
//   launch, launch_write         : start an access next cycle / its direction
//   launch_addr, launch_data     : address and write data of the access
//   pready                       : completion from the controller
//   paddr, pwdata, pwrite, penable : registered APB drive
//   done_c                       : access completes at this edge (pready seen)
//   timeout_c                    : access abandoned at this edge
module irq_apb_engine
    import irq_host_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             pclk,
    input  logic             preset,
    input  logic             launch,
    input  logic             launch_write,
    input  logic [WIDTH-1:0] launch_addr,
    input  logic [WIDTH-1:0] launch_data,
    input  logic             pready,
    output logic [WIDTH-1:0] paddr,
    output logic [WIDTH-1:0] pwdata,
    output logic             pwrite,
    output logic             penable,
    output logic             done_c,
    output logic             timeout_c
);

    logic                 active_q;
    logic [TIMEOUT_W-1:0] wait_q;

    assign done_c    = active_q & pready;
    // Last allowed wait cycle with pready still low.
    assign timeout_c = active_q & ~pready & (wait_q == TIMEOUT_W'(PREADY_TIMEOUT - 1));

    // Bus drive and wait counter.
    always_ff @(posedge pclk) begin
        if (preset) begin
            active_q <= 1'b0;
            wait_q   <= '0;
            paddr    <= '0;
            pwdata   <= '0;
            pwrite   <= 1'b0;
            penable  <= 1'b0;
        end else if (launch) begin
            active_q <= 1'b1;
            wait_q   <= '0;
            paddr    <= launch_addr;
            pwdata   <= launch_write ? launch_data : '0;
            pwrite   <= launch_write;
            penable  <= 1'b1;
        end else if (done_c || timeout_c) begin
            active_q <= 1'b0;
            wait_q   <= '0;
            paddr    <= '0;
            pwdata   <= '0;
            pwrite   <= 1'b0;
            penable  <= 1'b0;
        end else if (active_q) begin
            wait_q <= wait_q + TIMEOUT_W'(1);
        end
    end

endmodule

// File: rtl/irq_host_agent.sv
// Host agent: programs every peripheral priority over APB, reads each back to
// verify, then services interrupts presented by the controller one at a time.
// Ports:
//   pclk, preset            : clock, synchronous active-high reset
//   start                   : begin programming (honoured only in IDLE)
//   prio_table              : priority of peripheral i at [i*WIDTH +: WIDTH]
//   paddr/pwdata/pwrite/penable/pready/prdata : APB master side
//   interrupt_valid, interrupt_to_be_service  : pending interrupt from controller
//   interrupt_serviced, irq_clear             : one-cycle completion pulses
//   prog_done, prog_error, service_count      : status
module irq_host_agent
    import irq_host_pkg::*;
#(
    parameter int unsigned NO_OF_PERIPHERALS = 16,
    parameter int unsigned WIDTH             = $clog2(NO_OF_PERIPHERALS),
    parameter int unsigned SERVICE_CYCLES    = 4
) (
    input  logic                               pclk,
    input  logic                               preset,
    input  logic                               start,
    input  logic [NO_OF_PERIPHERALS*WIDTH-1:0] prio_table,
    output logic [WIDTH-1:0]                   paddr,
    output logic [WIDTH-1:0]                   pwdata,
    output logic                               pwrite,
    output logic                               penable,
    input  logic                               pready,
    input  logic [WIDTH-1:0]                   prdata,
    input  logic                               interrupt_valid,
    input  logic [WIDTH-1:0]                   interrupt_to_be_service,
    output logic                               interrupt_serviced,
    output logic [NO_OF_PERIPHERALS-1:0]       irq_clear,
    output logic                               prog_done,
    output logic                               prog_error,
    output logic [15:0]                        service_count
);

    localparam int unsigned SVC_W = (SERVICE_CYCLES > 1) ? $clog2(SERVICE_CYCLES) : 1;
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(NO_OF_PERIPHERALS - 1);

    host_state_e state_q, state_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] idx_inc;
    logic [SVC_W-1:0] svc_cnt_q, svc_cnt_d;
    logic [WIDTH-1:0] cap_id_q, cap_id_d;
    logic [WIDTH-1:0] prio_cur, prio_nxt;

    logic                         serviced_d;
    logic [NO_OF_PERIPHERALS-1:0] irq_clear_d;
    logic                         prog_done_d;
    logic                         prog_error_d;
    logic [15:0]                  service_count_d;

    logic             launch_c;
    logic             launch_write_c;
    logic [WIDTH-1:0] launch_addr_c;
    logic [WIDTH-1:0] launch_data_c;
    logic             done_c;
    logic             timeout_c;
    logic             acc_end_c;

    assign idx_inc   = idx_q + WIDTH'(1);
    assign prio_cur  = prio_table[32'(idx_q) * WIDTH +: WIDTH];
    assign prio_nxt  = prio_table[32'(idx_inc) * WIDTH +: WIDTH];
    assign acc_end_c = done_c | timeout_c;

    irq_apb_engine #(
        .WIDTH (WIDTH)
    ) u_apb_engine (
        .pclk         (pclk),
        .preset       (preset),
        .launch       (launch_c),
        .launch_write (launch_write_c),
        .launch_addr  (launch_addr_c),
        .launch_data  (launch_data_c),
        .pready       (pready),
        .paddr        (paddr),
        .pwdata       (pwdata),
        .pwrite       (pwrite),
        .penable      (penable),
        .done_c       (done_c),
        .timeout_c    (timeout_c)
    );

    // Next-state, access launch and next-output decode.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        svc_cnt_d       = svc_cnt_q;
        cap_id_d        = cap_id_q;
        launch_c        = 1'b0;
        launch_write_c  = 1'b0;
        launch_addr_c   = '0;
        launch_data_c   = '0;
        serviced_d      = 1'b0;
        irq_clear_d     = '0;
        prog_done_d     = prog_done;
        prog_error_d    = prog_error;
        service_count_d = service_count;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d        = WR_ACC;
                    idx_d          = '0;
                    launch_c       = 1'b1;
                    launch_write_c = 1'b1;
                    launch_addr_c  = '0;
                    launch_data_c  = prio_table[WIDTH-1:0];
                end
            end
            WR_ACC: begin
                if (acc_end_c) begin
                    state_d = WR_GAP;
                end
            end
            WR_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d       = RD_ACC;
                    idx_d         = '0;
                    launch_c      = 1'b1;
                    launch_addr_c = '0;
                end else begin
                    state_d        = WR_ACC;
                    idx_d          = idx_inc;
                    launch_c       = 1'b1;
                    launch_write_c = 1'b1;
                    launch_addr_c  = idx_inc;
                    launch_data_c  = prio_nxt;
                end
            end
            RD_ACC: begin
                if (acc_end_c) begin
                    state_d = RD_GAP;
                    // Compare only reads that actually completed.
                    if (done_c && (prdata != prio_cur)) begin
                        prog_error_d = 1'b1;
                    end
                end
            end
            RD_GAP: begin
                if (idx_q == LAST_IDX) begin
                    state_d     = READY;
                    prog_done_d = 1'b1;
                end else begin
                    state_d       = RD_ACC;
                    idx_d         = idx_inc;
                    launch_c      = 1'b1;
                    launch_addr_c = idx_inc;
                end
            end
            READY: begin
                if (interrupt_valid) begin
                    state_d   = SERVICE;
                    cap_id_d  = interrupt_to_be_service;
                    svc_cnt_d = SVC_W'(SERVICE_CYCLES - 1);
                end
            end
            SERVICE: begin
                if (svc_cnt_q == '0) begin
                    state_d     = ACK;
                    serviced_d  = 1'b1;
                    irq_clear_d = NO_OF_PERIPHERALS'(1) << cap_id_q;
                    if (service_count != SERVICE_COUNT_MAX) begin
                        service_count_d = service_count + 16'd1;
                    end
                end else begin
                    svc_cnt_d = svc_cnt_q - SVC_W'(1);
                end
            end
            ACK: begin
                state_d = HOLD;
            end
            HOLD: begin
                state_d = READY;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (timeout_c) begin
            prog_error_d = 1'b1;
        end
    end

    // State and registered outputs.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q            <= IDLE;
            idx_q              <= '0;
            svc_cnt_q          <= '0;
            cap_id_q           <= '0;
            interrupt_serviced <= 1'b0;
            irq_clear          <= '0;
            prog_done          <= 1'b0;
            prog_error         <= 1'b0;
            service_count      <= '0;
        end else begin
            state_q            <= state_d;
            idx_q              <= idx_d;
            svc_cnt_q          <= svc_cnt_d;
            cap_id_q           <= cap_id_d;
            interrupt_serviced <= serviced_d;
            irq_clear          <= irq_clear_d;
            prog_done          <= prog_done_d;
            prog_error         <= prog_error_d;
            service_count      <= service_count_d;
        end
    end

endmodule
